seg_scroll_ctrl: RTL and testbench
==================================

SEG_SCROLL_CTRL -- requirements
Module: seg_scroll_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of 4-bit digits displayed (2..16).
REQ-002 SHALL have parameter STEP_CYC, default 12_500_000, clock cycles per automatic step (250 ms at 50 MHz), minimum 2.
REQ-003 SHALL have port CLOCK_50  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port data_in  input  4*DIGITS  digit values; digit 0 in bits [3:0].
REQ-006 SHALL have port data_load  input  1  single-cycle strobe; captures data_in.
REQ-007 SHALL have port mode  input  2  00 static, 01 rotate-left, 10 rotate-right, 11 blink.
REQ-008 SHALL have port run  input  1  high enables automatic stepping from the step timer.
REQ-009 SHALL have port step_req  input  1  single-cycle manual step, e.g. a debounced key pulse.
REQ-010 SHALL have port frame  output  4*DIGITS  registered rotated digit word.
REQ-011 SHALL have port seg  output  7*DIGITS  registered active-low segments; digit k in bits [7k+6:7k].
REQ-012 SHALL have port step_pulse  output  1  registered one-cycle pulse for each step taken.

Function
REQ-013 SHALL hold a shadow register; it loads data_in in the cycle data_load is high.
REQ-014 SHALL keep an offset counter, 0..DIGITS-1, that wraps modulo DIGITS.
REQ-015 Rotate-left step SHALL increment offset (DIGITS-1 wraps to 0); frame digit k = shadow digit (k+offset) mod DIGITS.
REQ-016 Rotate-right step SHALL decrement offset (0 wraps to DIGITS-1).
REQ-017 Step timer SHALL count 0..STEP_CYC-1 while run=1 and mode!=00; a tick fires when it wraps to 0.
REQ-018 Step timer SHALL hold its value while run=0.
REQ-019 A step SHALL occur on a tick or on step_req, in any mode except static.
REQ-020 A tick and step_req in the same cycle SHALL produce exactly one step.
REQ-021 In static mode, offset SHALL stay 0, step_req SHALL be ignored, and step_pulse SHALL stay 0.
REQ-022 In blink mode, each step SHALL toggle a blank flag; offset SHALL stay unchanged.
REQ-023 While blank=1, every seg digit SHALL be 7'h7F; frame SHALL remain valid.
REQ-024 Any change of mode SHALL, in the next cycle, clear offset to 0, the timer to 0, and blank to 0; no step occurs that cycle.
REQ-025 data_load SHALL NOT alter offset, timer, or blank.
REQ-026 When data_load coincides with a step, the new shadow value and the new offset SHALL both appear in the same frame update.
REQ-027 frame and seg SHALL update exactly one cycle after the shadow, offset, or blank change that causes the update.
REQ-028 step_pulse SHALL assert in the same cycle as the resulting frame update.
REQ-029 Decoding SHALL map hex 0-F to the standard active-low pattern: 0=7'h40, 1=7'h79, 8=7'h00, F=7'h0E.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL clear shadow, offset, timer, and blank to 0, and set step_pulse to 0.
REQ-031 While rst=1, frame SHALL be 0 and every seg digit SHALL be 7'h40 (all zeros displayed).
REQ-032 rst SHALL take priority over data_load, step_req, and a mode change in the same cycle.
REQ-033 Reset applied mid-rotation SHALL discard any pending step.

Structure
REQ-034 Package seg_pkg SHALL hold the mode encodings (MODE_STATIC, MODE_ROTL, MODE_ROTR, MODE_BLINK), SEG_BLANK=7'h7F, and the hex-to-segment table.
REQ-035 Decoding SHALL be done by a combinational sub-module, seg7_hex_dec (4-bit in, 7-bit active-low out), instantiated DIGITS times.
REQ-036 Offset arithmetic SHALL be done at width $clog2(DIGITS) with explicit wrap; it SHALL NOT rely on natural overflow.

Verification (bench parameters DIGITS=8, STEP_CYC=4)
REQ-037 Reset then load 0x76543210, mode=01, run=1 -> step_pulse every 4 cycles; frame 0x07654321, then 0x10765432.
REQ-038 Mode=10, run=0, pulse step_req once at offset 0 -> offset wraps to 7; frame 0x65432107 one cycle later.
REQ-039 Tick and step_req in the same cycle -> exactly one step_pulse and an offset change of one.
REQ-040 Mode=11, run=1 -> seg alternates between all-7'h7F and decoded digits every 4 cycles; frame is constant.
REQ-041 Change mode from 01 at offset 5 to 10 -> offset 0 and timer restarted; assert rst mid-count -> outputs per REQ-030/031 on the next edge.

Source files
------------

// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the scrolling seven-segment controller.
//   mode_t         : operating mode encodings driven on the 'mode' port
//   SEG_BLANK      : active-low pattern with every segment dark
//   SEG_ZERO       : active-low pattern that shows the digit 0
//   HEX_SEG_TABLE  : hex value -> active-low segment pattern {g,f,e,d,c,b,a}
// ----------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_ROTL   = 2'b01,
        MODE_ROTR   = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    // Index 0 is the first element; bit 6 is segment g, bit 0 is segment a.
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_hex_dec.sv
// ----------------------------------------------------------------------------
// seg7_hex_dec
// Purely combinational hex to seven-segment decoder, active-low outputs.
//   i_hex : 4-bit digit value 0..F
//   o_seg : active-low segment pattern {g,f,e,d,c,b,a}
// ----------------------------------------------------------------------------
module seg7_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG_TABLE[i_hex];

endmodule

// File: rtl/seg_scroll_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scroll_ctrl
// Holds a word of hex digits and presents it on a multi-digit seven-segment
// display, either static, rotating left/right, or blinking. Steps come from
// an internal step timer (when 'run' is high) or from a manual 'step_req'.
//
// Parameters
//   DIGITS     : number of 4-bit digits (2..16)
//   STEP_CYC   : clock cycles per automatic step (>= 2)
//
// Ports
//   CLOCK_50   : sole clock, rising edge
//   rst        : synchronous active-high reset
//   data_in    : digit values, digit 0 in bits [3:0]
//   data_load  : one-cycle strobe, captures data_in into the shadow register
//   mode       : 00 static, 01 rotate-left, 10 rotate-right, 11 blink
//   run        : enables automatic stepping from the step timer
//   step_req   : one-cycle manual step request
//   frame      : registered rotated digit word
//   seg        : registered active-low segments, digit k in [7k+6:7k]
//   step_pulse : registered one-cycle pulse, aligned with the frame update
//                that a step produces
// ----------------------------------------------------------------------------
module seg_scroll_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int STEP_CYC = 12_500_000
) (
    input  logic                  CLOCK_50,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic                  data_load,
    input  logic [1:0]            mode,
    input  logic                  run,
    input  logic                  step_req,
    output logic [4*DIGITS-1:0]   frame,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  step_pulse
);

    localparam int OFFW = $clog2(DIGITS);
    localparam int TMRW = $clog2(STEP_CYC);

    localparam logic [OFFW-1:0] OFF_LAST = OFFW'(DIGITS - 1);
    localparam logic [TMRW-1:0] TMR_LAST = TMRW'(STEP_CYC - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] r_shadow;
    logic [OFFW-1:0]     r_offset;
    logic [TMRW-1:0]     r_timer;
    logic                r_blank;
    logic [1:0]          r_prevMode;
    logic                r_stepPend;

    logic [4*DIGITS-1:0] r_frame;
    logic [7*DIGITS-1:0] r_seg;
    logic                r_stepPulse;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    mode_t               w_mode;
    logic                w_modeChange;
    logic                w_active;
    logic                w_timerRun;
    logic                w_tick;
    logic                w_step;

    logic [OFFW-1:0]     w_offsetNext;
    logic [TMRW-1:0]     w_timerNext;
    logic                w_blankNext;

    logic [4*DIGITS-1:0] w_frame;
    logic [7*DIGITS-1:0] w_segDec;

    assign w_mode       = mode_t'(mode);
    assign w_modeChange = (mode != r_prevMode);
    assign w_active     = (w_mode != MODE_STATIC);

    // The cycle in which a mode change is seen only clears state, so both
    // the timer and the step are suppressed there.
    assign w_timerRun   = run && w_active && !w_modeChange;
    assign w_tick       = w_timerRun && (r_timer == TMR_LAST);

    // A tick and a manual request in the same cycle merge into one step.
    assign w_step       = w_active && !w_modeChange && (w_tick || step_req);

    // Next offset / timer / blank. Offset wraps explicitly at DIGITS-1 so
    // that non-power-of-two digit counts behave correctly.
    always_comb begin
        w_offsetNext = r_offset;
        w_timerNext  = r_timer;
        w_blankNext  = r_blank;
        if (w_modeChange) begin
            w_offsetNext = '0;
            w_timerNext  = '0;
            w_blankNext  = 1'b0;
        end else begin
            if (w_timerRun) begin
                w_timerNext = (r_timer == TMR_LAST) ? '0 : r_timer + 1'b1;
            end
            if (w_step) begin
                case (w_mode)
                    MODE_ROTL:  w_offsetNext = (r_offset == OFF_LAST) ? '0 : r_offset + 1'b1;
                    MODE_ROTR:  w_offsetNext = (r_offset == '0) ? OFF_LAST : r_offset - 1'b1;
                    MODE_BLINK: w_blankNext  = !r_blank;
                    default:    ;
                endcase
            end
        end
    end

    // Frame digit k is shadow digit (k + offset) mod DIGITS.
    always_comb begin : p_rotate
        int src;
        w_frame = '0;
        for (int k = 0; k < DIGITS; k++) begin
            src = k + int'(r_offset);
            if (src >= DIGITS) begin
                src = src - DIGITS;
            end
            w_frame[4*k +: 4] = r_shadow[4*src +: 4];
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_dec
        seg7_hex_dec u_dec (
            .i_hex (w_frame[4*k +: 4]),
            .o_seg (w_segDec[7*k +: 7])
        );
    end

    // ------------------------------------------------------------------
    // Control state registers. Reset wins over load, step and mode change.
    // r_prevMode tracks 'mode' even in reset so that leaving reset is not
    // mistaken for a mode change.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_shadow   <= '0;
            r_offset   <= '0;
            r_timer    <= '0;
            r_blank    <= 1'b0;
            r_prevMode <= mode;
            r_stepPend <= 1'b0;
        end else begin
            if (data_load) begin
                r_shadow <= data_in;
            end
            r_offset   <= w_offsetNext;
            r_timer    <= w_timerNext;
            r_blank    <= w_blankNext;
            r_prevMode <= mode;
            r_stepPend <= w_step;
        end
    end

    // ------------------------------------------------------------------
    // Output registers: one cycle behind the control state, so the step
    // pulse is delayed by r_stepPend to line up with the new frame.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_frame     <= '0;
            r_seg       <= {DIGITS{SEG_ZERO}};
            r_stepPulse <= 1'b0;
        end else begin
            r_frame     <= w_frame;
            r_seg       <= r_blank ? {DIGITS{SEG_BLANK}} : w_segDec;
            r_stepPulse <= r_stepPend;
        end
    end

    assign frame      = r_frame;
    assign seg        = r_seg;
    assign step_pulse = r_stepPulse;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seg_scroll_ctrl
// Self-checking bench for seg_scroll_ctrl with DIGITS=8, STEP_CYC=4.
// A behavioural model tracks shadow word, offset, step timer and blank flag
// with plain arithmetic and predicts the registered outputs.
// ----------------------------------------------------------------------------
module tb_seg_scroll_ctrl;

    localparam int DIGITS   = 8;
    localparam int STEP_CYC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        data_load;
    logic [1:0]  mode;
    logic        run;
    logic        step_req;
    logic [31:0] frame;
    logic [55:0] seg;
    logic        step_pulse;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    seg_scroll_ctrl #(
        .DIGITS   (DIGITS),
        .STEP_CYC (STEP_CYC)
    ) dut (
        .CLOCK_50   (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_load  (data_load),
        .mode       (mode),
        .run        (run),
        .step_req   (step_req),
        .frame      (frame),
        .seg        (seg),
        .step_pulse (step_pulse)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [31:0] mShadow   = '0;
    int          mOffset   = 0;
    int          mTimer    = 0;
    bit          mBlank    = 1'b0;
    bit          mPend     = 1'b0;
    logic [1:0]  mPrevMode = 2'b00;

    logic [31:0] expFrame = '0;
    logic [55:0] expSeg   = '0;
    bit          expPulse = 1'b0;

    function automatic logic [6:0] hexSeg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [31:0] rotWord(input logic [31:0] w, input int off);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = w[4*((k + off) % DIGITS) +: 4];
        end
        return r;
    endfunction

    function automatic logic [55:0] segWord(input logic [31:0] f);
        logic [55:0] s;
        for (int k = 0; k < DIGITS; k++) begin
            s[7*k +: 7] = hexSeg(f[4*k +: 4]);
        end
        return s;
    endfunction

    // Advance the model by one clock edge using the inputs now applied.
    task automatic modelEdge();
        bit tick;
        bit stepNow;
        if (rst) begin
            mShadow   = '0;
            mOffset   = 0;
            mTimer    = 0;
            mBlank    = 1'b0;
            mPend     = 1'b0;
            mPrevMode = mode;
            expFrame  = '0;
            expSeg    = {DIGITS{7'h40}};
            expPulse  = 1'b0;
            return;
        end
        expFrame = rotWord(mShadow, mOffset);
        expSeg   = mBlank ? {DIGITS{7'h7F}} : segWord(expFrame);
        expPulse = mPend;
        if (mode != mPrevMode) begin
            mOffset = 0;
            mTimer  = 0;
            mBlank  = 1'b0;
            mPend   = 1'b0;
        end else if (mode != 2'b00) begin
            tick = 1'b0;
            if (run) begin
                mTimer = mTimer + 1;
                if (mTimer == STEP_CYC) begin
                    mTimer = 0;
                    tick   = 1'b1;
                end
            end
            stepNow = tick || step_req;
            if (stepNow) begin
                if (mode == 2'b01)      mOffset = (mOffset + 1) % DIGITS;
                else if (mode == 2'b10) mOffset = (mOffset + DIGITS - 1) % DIGITS;
                else                    mBlank  = !mBlank;
            end
            mPend = stepNow;
        end else begin
            mPend = 1'b0;
        end
        mPrevMode = mode;
        if (data_load) mShadow = data_in;
    endtask

    task automatic clockStep();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; mode = 2'b00; run = 1'b0; step_req = 1'b0;
        data_load = 1'b0; data_in = '0;
        clockStep();
        clockStep();
        testCount++;
        if (frame !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL reset_frame got=%h want=%h", frame, 32'h0);
        end
        testCount++;
        if (seg !== {DIGITS{7'h40}}) begin
            failCount++;
            $display("[TB] FAIL reset_seg got=%h want=%h", seg, {DIGITS{7'h40}});
        end
        testCount++;
        if (step_pulse !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_pulse got=%b want=0", step_pulse);
        end
    endtask

    task automatic test_rotate_left();
        logic [31:0] pf [2];
        int          pc [2];
        int          pulses;
        pulses = 0;
        rst = 1'b1; mode = 2'b01; run = 1'b1;
        clockStep();
        rst = 1'b0; data_load = 1'b1; data_in = 32'h76543210;
        clockStep();
        data_load = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            clockStep();
            testCount++;
            if ({frame, seg, step_pulse} !== {expFrame, expSeg, expPulse}) begin
                failCount++;
                $display("[TB] FAIL rotl_model n=%0d frame=%h/%h seg=%h/%h pulse=%b/%b",
                         n, frame, expFrame, seg, expSeg, step_pulse, expPulse);
            end
            if (step_pulse === 1'b1) begin
                if (pulses < 2) begin
                    pf[pulses] = frame;
                    pc[pulses] = n;
                end
                pulses++;
            end
        end
        testCount++;
        if (pulses < 2) begin
            failCount++;
            $display("[TB] FAIL rotl_pulse_count got=%0d want>=2", pulses);
        end else begin
            testCount++;
            if (pf[0] !== 32'h07654321) begin
                failCount++;
                $display("[TB] FAIL rotl_first_frame got=%h want=07654321", pf[0]);
            end
            testCount++;
            if (pf[1] !== 32'h10765432) begin
                failCount++;
                $display("[TB] FAIL rotl_second_frame got=%h want=10765432", pf[1]);
            end
            testCount++;
            if (pc[1] - pc[0] != STEP_CYC) begin
                failCount++;
                $display("[TB] FAIL rotl_pulse_gap got=%0d want=%0d", pc[1] - pc[0], STEP_CYC);
            end
        end
    endtask

    task automatic test_rotate_right_manual();
        mode = 2'b10; run = 1'b0;
        clockStep();
        clockStep();
        testCount++;
        if (frame !== 32'h76543210) begin
            failCount++;
            $display("[TB] FAIL rotr_cleared got=%h want=76543210", frame);
        end
        step_req = 1'b1;
        clockStep();
        step_req = 1'b0;
        clockStep();
        testCount++;
        if (frame !== 32'h65432107 || step_pulse !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL rotr_wrap frame=%h want=65432107 pulse=%b want=1", frame, step_pulse);
        end
        clockStep();
        testCount++;
        if (step_pulse !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rotr_no_autostep got=%b want=0", step_pulse);
        end
    endtask

    task automatic test_tick_and_req();
        bit found;
        found = 1'b0;
        mode = 2'b01; run = 1'b1;
        clockStep();
        for (int n = 0; n < 10; n++) begin
            if (mTimer == STEP_CYC - 1) begin
                found = 1'b1;
                break;
            end
            clockStep();
        end
        testCount++;
        if (!found) begin
            failCount++;
            $display("[TB] FAIL tickreq_timeout got=no_tick want=tick");
        end else begin
            step_req = 1'b1;
            clockStep();
            step_req = 1'b0;
            clockStep();
            testCount++;
            if (frame !== 32'h07654321 || step_pulse !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL tickreq_single_step frame=%h want=07654321 pulse=%b want=1",
                         frame, step_pulse);
            end
            clockStep();
            testCount++;
            if (step_pulse !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL tickreq_one_pulse got=%b want=0", step_pulse);
            end
        end
    endtask

    task automatic test_blink();
        logic [55:0] ps [2];
        int          pc [2];
        int          pulses;
        pulses = 0;
        mode = 2'b11; run = 1'b1;
        clockStep();
        for (int n = 1; n <= 17; n++) begin
            clockStep();
            testCount++;
            if ({frame, seg, step_pulse} !== {expFrame, expSeg, expPulse}) begin
                failCount++;
                $display("[TB] FAIL blink_model n=%0d frame=%h/%h seg=%h/%h pulse=%b/%b",
                         n, frame, expFrame, seg, expSeg, step_pulse, expPulse);
            end
            testCount++;
            if (frame !== 32'h76543210) begin
                failCount++;
                $display("[TB] FAIL blink_frame n=%0d got=%h want=76543210", n, frame);
            end
            if (step_pulse === 1'b1) begin
                if (pulses < 2) begin
                    ps[pulses] = seg;
                    pc[pulses] = n;
                end
                pulses++;
            end
        end
        testCount++;
        if (pulses < 2) begin
            failCount++;
            $display("[TB] FAIL blink_pulse_count got=%0d want>=2", pulses);
        end else begin
            testCount++;
            if (ps[0] !== {DIGITS{7'h7F}}) begin
                failCount++;
                $display("[TB] FAIL blink_dark got=%h want=%h", ps[0], {DIGITS{7'h7F}});
            end
            testCount++;
            if (ps[1] !== segWord(32'h76543210)) begin
                failCount++;
                $display("[TB] FAIL blink_lit got=%h want=%h", ps[1], segWord(32'h76543210));
            end
            testCount++;
            if (pc[1] - pc[0] != STEP_CYC) begin
                failCount++;
                $display("[TB] FAIL blink_gap got=%0d want=%0d", pc[1] - pc[0], STEP_CYC);
            end
        end
    endtask

    task automatic test_mode_change_and_reset();
        bit found;
        int firstPulse;
        logic [31:0] pulseFrame;
        found = 1'b0;
        firstPulse = -1;
        pulseFrame = '0;
        mode = 2'b01; run = 1'b1;
        clockStep();
        for (int n = 0; n < 40; n++) begin
            if (mOffset == 5) begin
                found = 1'b1;
                break;
            end
            clockStep();
        end
        testCount++;
        if (!found) begin
            failCount++;
            $display("[TB] FAIL modechg_reach5 got=%0d want=5", mOffset);
        end
        mode = 2'b10;
        clockStep();
        for (int n = 1; n <= 8; n++) begin
            clockStep();
            if (n == 1) begin
                testCount++;
                if (frame !== 32'h76543210) begin
                    failCount++;
                    $display("[TB] FAIL modechg_offset_clear got=%h want=76543210", frame);
                end
            end
            if (step_pulse === 1'b1 && firstPulse < 0) begin
                firstPulse = n;
                pulseFrame = frame;
            end
        end
        testCount++;
        if (firstPulse != STEP_CYC + 1 || pulseFrame !== 32'h65432107) begin
            failCount++;
            $display("[TB] FAIL modechg_timer_restart pulse_at=%0d want=%0d frame=%h want=65432107",
                     firstPulse, STEP_CYC + 1, pulseFrame);
        end
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (mPend) begin
                found = 1'b1;
                break;
            end
            clockStep();
        end
        testCount++;
        if (!found) begin
            failCount++;
            $display("[TB] FAIL rst_pending_setup got=no_step want=step");
        end
        rst = 1'b1; data_load = 1'b1; data_in = $urandom; step_req = 1'b1; mode = 2'b01;
        clockStep();
        data_load = 1'b0; step_req = 1'b0;
        testCount++;
        if (frame !== 32'h0 || seg !== {DIGITS{7'h40}} || step_pulse !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rst_midrun frame=%h want=0 seg=%h want=%h pulse=%b want=0",
                     frame, seg, {DIGITS{7'h40}}, step_pulse);
        end
        clockStep();
        rst = 1'b0;
        clockStep();
        clockStep();
        testCount++;
        if (frame !== 32'h0 || seg !== {DIGITS{7'h40}}) begin
            failCount++;
            $display("[TB] FAIL rst_shadow_cleared frame=%h want=0 seg=%h want=%h",
                     frame, seg, {DIGITS{7'h40}});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            data_load = ($urandom_range(0, 7) == 0);
            data_in   = $urandom;
            if ($urandom_range(0, 23) == 0) mode = 2'($urandom_range(0, 3));
            run       = ($urandom_range(0, 3) != 0);
            step_req  = ($urandom_range(0, 5) == 0);
            clockStep();
            testCount++;
            if ({frame, seg, step_pulse} !== {expFrame, expSeg, expPulse}) begin
                failCount++;
                $display("[TB] FAIL random_model i=%0d frame=%h/%h seg=%h/%h pulse=%b/%b",
                         i, frame, expFrame, seg, expSeg, step_pulse, expPulse);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotate_left();
        test_rotate_right_manual();
        test_tick_and_req();
        test_blink();
        test_mode_change_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
